// File: rtl/cgol_vector_checker.sv
// On-chip vector checker for the cgol core: replays stored expected vectors against DUT outputs on ph2.
// Optional build macro CGOL_CHK_MASK_EN adds a per-bit care-mask memory and the ld_mask port.
module cgol_vector_checker #(
  parameter int NCH         = 2,
  parameter int W           = 8,
  parameter int DEPTH       = 512,
  parameter int ERRW        = 16,
  parameter int STOP_ON_ERR = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              ph1,
  input  logic              ph2,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [NCH*W-1:0]  ld_data,
`ifdef CGOL_CHK_MASK_EN
  input  logic [NCH*W-1:0]  ld_mask,
`endif
  input  logic              ld_last,
  input  logic [NCH*W-1:0]  dut_out,
  input  logic              dut_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERRW-1:0]   err_count,
  output logic [AW:0]       vec_count,
  output logic [AW-1:0]     first_err,
  output logic [NCH-1:0]    first_mask
);

  localparam int DW = NCH * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [AW-1:0]     ptr_r, ptr_s;
  logic [AW:0]       num_vec_r, num_vec_s;
  logic [ERRW-1:0]   err_s;
  logic [AW:0]       vec_s;
  logic [AW-1:0]     first_err_s;
  logic [NCH-1:0]    first_mask_s;
  logic [NCH-1:0]    mis_s;
  logic              last_s;
  logic              wr_en_s;

  logic [DW-1:0]     exp_mem [DEPTH];
  logic [DW-1:0]     exp_q;
  logic [DW-1:0]     mask_q;

  // Per-channel mismatch flags, considering only bits marked as cared-for.
  function automatic logic [NCH-1:0] chan_mismatch(input logic [DW-1:0] got,
                                                   input logic [DW-1:0] want,
                                                   input logic [DW-1:0] care);
    logic [NCH-1:0] m;
    m = {NCH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      m[c] = |((got[c*W +: W] ^ want[c*W +: W]) & care[c*W +: W]);
    end
    return m;
  endfunction

  // start takes priority over a same-cycle load, and loads are frozen during a run
  assign wr_en_s = ld_we && !start && (state_r != RUN) && reset;

  // Expected-vector memory write port.
  always_ff @(posedge ph2) begin
    if (wr_en_s) begin
      exp_mem[ld_addr] <= ld_data;
    end
  end

  // Expected-vector read register, one ph1 ahead of the ph2 compare.
  always_ff @(posedge ph1) begin
    exp_q <= exp_mem[ptr_r];
  end

`ifdef CGOL_CHK_MASK_EN
  logic [DW-1:0] mask_mem [DEPTH];

  // Care-mask memory write port.
  always_ff @(posedge ph2) begin
    if (wr_en_s) begin
      mask_mem[ld_addr] <= ld_mask;
    end
  end

  // Care-mask read register, aligned with exp_q.
  always_ff @(posedge ph1) begin
    mask_q <= mask_mem[ptr_r];
  end
`else
  assign mask_q = {DW{1'b1}};
`endif

  assign mis_s = chan_mismatch(dut_out, exp_q, mask_q);

  // Next-state and next-counter logic.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    num_vec_s    = num_vec_r;
    err_s        = err_count;
    vec_s        = vec_count;
    first_err_s  = first_err;
    first_mask_s = first_mask;
    last_s       = ({1'b0, ptr_r} == (num_vec_r - {{AW{1'b0}}, 1'b1}));
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          ptr_s        = {AW{1'b0}};
          err_s        = {ERRW{1'b0}};
          vec_s        = {(AW+1){1'b0}};
          first_err_s  = {AW{1'b0}};
          first_mask_s = {NCH{1'b0}};
          state_s      = (num_vec_r != {(AW+1){1'b0}}) ? RUN : DONE;
        end else if (ld_we && ld_last) begin
          num_vec_s = {1'b0, ld_addr} + {{AW{1'b0}}, 1'b1};
        end else begin
          num_vec_s = num_vec_r;
        end
      end
      RUN: begin
        if (dut_valid) begin
          vec_s = vec_count + {{AW{1'b0}}, 1'b1};
          if (|mis_s) begin
            if (err_count != {ERRW{1'b1}}) begin
              err_s = err_count + {{(ERRW-1){1'b0}}, 1'b1};
            end else begin
              err_s = err_count;
            end
            // err_count can only be zero here before the first mismatch of the run
            if (err_count == {ERRW{1'b0}}) begin
              first_err_s  = ptr_r;
              first_mask_s = mis_s;
            end else begin
              first_err_s  = first_err;
              first_mask_s = first_mask;
            end
          end else begin
            err_s = err_count;
          end
          if (last_s || ((STOP_ON_ERR != 0) && (|mis_s))) begin
            state_s = DONE;
          end else begin
            ptr_s = ptr_r + {{(AW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge ph2) begin
    if (!reset) begin
      state_r    <= IDLE;
      ptr_r      <= {AW{1'b0}};
      num_vec_r  <= {(AW+1){1'b0}};
      err_count  <= {ERRW{1'b0}};
      vec_count  <= {(AW+1){1'b0}};
      first_err  <= {AW{1'b0}};
      first_mask <= {NCH{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      num_vec_r  <= num_vec_s;
      err_count  <= err_s;
      vec_count  <= vec_s;
      first_err  <= first_err_s;
      first_mask <= first_mask_s;
      busy       <= (state_s == RUN);
      done       <= (state_s == DONE);
      pass       <= (state_s == DONE) && (vec_s != {(AW+1){1'b0}}) && (err_s == {ERRW{1'b0}});
    end
  end

endmodule

// File: tb/tb_cgol_vector_checker.sv
// Scoreboard bench for cgol_vector_checker: three instances (default, stop-on-error, 2-bit error counter)
// share one directed stimulus stream; expected run results are queued and checked when done rises.
module tb_cgol_vector_checker;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          ph1, ph2, reset, start, ld_we, ld_last, dut_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data, dut_out;
  logic [DW-1:0] cur_mask;
`ifdef CGOL_CHK_MASK_EN
  logic [DW-1:0] ld_mask;
`endif

  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [15:0] err_a, err_b;
  logic [1:0]  err_c;
  logic [AW:0] vec_a, vec_b, vec_c;
  logic [AW-1:0] fe_a, fe_b, fe_c;
  logic [1:0]  fm_a, fm_b, fm_c;

  typedef struct packed {
    logic [15:0]   err;
    logic [AW:0]   vec;
    logic [AW-1:0] fe;
    logic [1:0]    fm;
    logic          pass;
  } res_t;

  res_t q_a[$], q_b[$], q_c[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic pd_a = 1'b0, pd_b = 1'b0, pd_c = 1'b0;

  cgol_vector_checker dut_a (
    .ph1(ph1), .ph2(ph2), .reset(reset), .start(start), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data),
`ifdef CGOL_CHK_MASK_EN
    .ld_mask(ld_mask),
`endif
    .ld_last(ld_last), .dut_out(dut_out), .dut_valid(dut_valid), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .vec_count(vec_a), .first_err(fe_a), .first_mask(fm_a));

  cgol_vector_checker #(.STOP_ON_ERR(1)) dut_b (
    .ph1(ph1), .ph2(ph2), .reset(reset), .start(start), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data),
`ifdef CGOL_CHK_MASK_EN
    .ld_mask(ld_mask),
`endif
    .ld_last(ld_last), .dut_out(dut_out), .dut_valid(dut_valid), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .vec_count(vec_b), .first_err(fe_b), .first_mask(fm_b));

  cgol_vector_checker #(.ERRW(2)) dut_c (
    .ph1(ph1), .ph2(ph2), .reset(reset), .start(start), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data),
`ifdef CGOL_CHK_MASK_EN
    .ld_mask(ld_mask),
`endif
    .ld_last(ld_last), .dut_out(dut_out), .dut_valid(dut_valid), .busy(busy_c), .done(done_c),
    .pass(pass_c), .err_count(err_c), .vec_count(vec_c), .first_err(fe_c), .first_mask(fm_c));

  // Non-overlapping two-phase clock: ph1 high 2..6, ph2 high 10..14, period 20.
  initial begin
    ph1 = 1'b0;
    ph2 = 1'b0;
    forever begin
      #2 ph1 = 1'b1;
      #4 ph1 = 1'b0;
      #4 ph2 = 1'b1;
      #4 ph2 = 1'b0;
      #6;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic [15:0] e, input logic [AW:0] v, input logic [AW-1:0] f,
                              input logic [1:0] m, input logic p);
    res_t r;
    r.err = e; r.vec = v; r.fe = f; r.fm = m; r.pass = p;
    return r;
  endfunction

  task automatic cmp_res(input string nm, input res_t act, input res_t exp);
    check({nm, ".vec_count"},  32'(act.vec),  32'(exp.vec));
    check({nm, ".err_count"},  32'(act.err),  32'(exp.err));
    check({nm, ".first_err"},  32'(act.fe),   32'(exp.fe));
    check({nm, ".first_mask"}, 32'(act.fm),   32'(exp.fm));
    check({nm, ".pass"},       32'(act.pass), 32'(exp.pass));
  endtask

  // Monitor: on each rising done, pop the expected result for that instance and compare.
  always @(negedge ph2) begin
    if (done_a === 1'b1 && !pd_a) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++; $display("FAIL dut_a: unexpected done, no queued expectation");
      end else begin
        cmp_res("dut_a", mk(err_a, vec_a, fe_a, fm_a, pass_a), q_a.pop_front());
      end
    end
    if (done_b === 1'b1 && !pd_b) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++; $display("FAIL dut_b: unexpected done, no queued expectation");
      end else begin
        cmp_res("dut_b", mk(err_b, vec_b, fe_b, fm_b, pass_b), q_b.pop_front());
      end
    end
    if (done_c === 1'b1 && !pd_c) begin
      if (q_c.size() == 0) begin
        n_cmp++; n_bad++; $display("FAIL dut_c: unexpected done, no queued expectation");
      end else begin
        cmp_res("dut_c", mk({14'b0, err_c}, vec_c, fe_c, fm_c, pass_c), q_c.pop_front());
      end
    end
    pd_a <= (done_a === 1'b1);
    pd_b <= (done_b === 1'b1);
    pd_c <= (done_c === 1'b1);
  end

  // One ph2 cycle of stimulus; inputs change on falling ph1, well away from ph2.
  task automatic step(input logic rst, input logic st, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic lst, input logic [DW-1:0] o, input logic v);
    @(negedge ph1);
    reset = rst; start = st; ld_we = we; ld_addr = a; ld_data = d; ld_last = lst;
    dut_out = o; dut_valid = v;
`ifdef CGOL_CHK_MASK_EN
    ld_mask = cur_mask;
`endif
  endtask

  task automatic idle();                      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0); endtask
  task automatic go();                        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0); endtask
  task automatic stall();                     step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0); endtask
  task automatic drive(input logic [DW-1:0] o); step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, o, 1'b1); endtask
  task automatic load(input int a, input logic [DW-1:0] d, input logic lst);
    step(1'b1, 1'b0, 1'b1, AW'(a), d, lst, '0, 1'b0);
  endtask

  function automatic logic [DW-1:0] vd(input int i);
    logic [7:0] hi, lo;
    hi = 8'(i + 1);
    lo = 8'(i + 2);
    return {hi, lo};
  endfunction

  task automatic push_all(input res_t ea, input res_t eb, input res_t ec);
    q_a.push_back(ea); q_b.push_back(eb); q_c.push_back(ec);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy_a"}, 32'(busy_a), 32'd0);
    check({tag, " done_a"}, 32'(done_a), 32'd0);
    check({tag, " pass_a"}, 32'(pass_a), 32'd0);
    check({tag, " err_a"},  32'(err_a),  32'd0);
    check({tag, " vec_a"},  32'(vec_a),  32'd0);
    check({tag, " busy_b"}, 32'(busy_b), 32'd0);
    check({tag, " vec_b"},  32'(vec_b),  32'd0);
    check({tag, " done_c"}, 32'(done_c), 32'd0);
    check({tag, " err_c"},  32'(err_c),  32'd0);
    check({tag, " fe_a"},   32'(fe_a),   32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
    dut_out = '0; dut_valid = 1'b0; cur_mask = '1;
`ifdef CGOL_CHK_MASK_EN
    ld_mask = '1;
`endif
    // Reset held across two ph2 edges.
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    idle();
    check_idle("reset");

    // Four matching vectors; a write issued during the run must be ignored.
    for (int i = 0; i < 4; i++) load(i, vd(i), i == 3);
    push_all(mk(0, 4, 0, 2'b00, 1), mk(0, 4, 0, 2'b00, 1), mk(0, 4, 0, 2'b00, 1));
    go();
    step(1'b1, 1'b0, 1'b1, '0, 16'hDEAD, 1'b1, vd(0), 1'b1);
    for (int i = 1; i < 4; i++) drive(vd(i));
    idle(); idle();

    // Restart from DONE with a same-cycle write (dropped); vector 2 channel 1 wrong.
    push_all(mk(1, 4, 2, 2'b10, 0), mk(1, 3, 2, 2'b10, 0), mk(1, 4, 2, 2'b10, 0));
    step(1'b1, 1'b1, 1'b1, AW'(1), 16'hBEEF, 1'b0, '0, 1'b0);
    drive(vd(0));
    drive(vd(1));
    drive({8'hFF, vd(2)[7:0]});
    drive(vd(3));
    idle(); idle();

    // Stalls between valid vectors are neither compared nor counted.
    push_all(mk(0, 4, 0, 2'b00, 1), mk(0, 4, 0, 2'b00, 1), mk(0, 4, 0, 2'b00, 1));
    go();
    drive(vd(0));
    stall();
    stall();
    check("stall vec_a", 32'(vec_a), 32'd1);
    check("stall busy_a", 32'(busy_a), 32'd1);
    drive(vd(1));
    stall();
    drive(vd(2));
    drive(vd(3));
    idle(); idle();

    // Reset mid-run aborts; a start without reload ends empty with pass low.
    go();
    drive(vd(0));
    drive(vd(1));
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    idle();
    check_idle("midrun reset");
    push_all(mk(0, 0, 0, 2'b00, 0), mk(0, 0, 0, 2'b00, 0), mk(0, 0, 0, 2'b00, 0));
    go();
    idle(); idle();

    // Five all-wrong vectors: 2-bit counter saturates, stop-on-error ends at the first.
    for (int i = 0; i < 5; i++) load(i, vd(i), i == 4);
    push_all(mk(5, 5, 0, 2'b11, 0), mk(1, 1, 0, 2'b11, 0), mk(3, 5, 0, 2'b11, 0));
    go();
    for (int i = 0; i < 5; i++) drive(~vd(i));
    idle(); idle();

`ifdef CGOL_CHK_MASK_EN
    // Channel 0 upper nibble is don't-care.
    cur_mask = {8'hFF, 8'h0F};
    load(0, {8'h11, 8'h22}, 1'b1);
    cur_mask = '1;
    push_all(mk(0, 1, 0, 2'b00, 1), mk(0, 1, 0, 2'b00, 1), mk(0, 1, 0, 2'b00, 1));
    go();
    drive({8'h11, 8'hF2});
    idle(); idle();
`endif

    for (int k = 0; k < 20 && (q_a.size() + q_b.size() + q_c.size()) > 0; k++) idle();
    while (q_a.size() + q_b.size() + q_c.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d/%0d/%0d expected results never seen", q_a.size(), q_b.size(), q_c.size());
      q_a.delete(); q_b.delete(); q_c.delete();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
